// File: rtl/uart_word_loader.sv
// ============================================================================
// uart_word_loader
//
// Turns a stream of UART bytes into 32-bit memory writes. The stream starts
// with a 4-byte little-endian word count N. It is followed by N little-endian
// 32-bit words, which are written to consecutive word addresses starting at 0.
// A load that stalls for too long between bytes is aborted into an error
// state. Both terminal states (DONE, ERR) wait for a restart pulse.
//
// Parameters
//   ADDR_W   word-address width of the target memory (assumed < 32)
//   TIMEOUT  inter-byte timeout in clk cycles (assumed >= 2)
//
// Ports
//   clk        single clock, rising-edge
//   rst_n      asynchronous active-low reset
//   rx_data    received byte, valid while rx_ready is high
//   rx_ready   receiver level flag; a rising edge marks a new byte
//   restart    synchronous pulse; re-arms the loader from DONE or ERR
//   mem_we     one-cycle memory write strobe
//   mem_addr   word address of the current write
//   mem_wdata  word being written
//   busy       a load is in progress (header partly received, or data phase)
//   done       load finished (DONE state)
//   error      load aborted (ERR state)
// ============================================================================
module uart_word_loader #(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 2000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    input  logic              restart,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error
);

    // Timeout counter only needs to reach TIMEOUT-1.
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    // The counter value at which the next idle cycle makes it reach TIMEOUT-1.
    localparam logic [TW-1:0] TO_HIT = TW'(TIMEOUT - 2);

    // Largest legal word count: exactly fills the memory.
    localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_W;

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        DATA = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              rdy_q;
    logic [1:0]        byte_idx;
    logic [1:0]        byte_idx_next;
    logic [31:0]       word_q;
    logic [31:0]       word_next;
    logic [ADDR_W:0]   addr_cnt;
    logic [ADDR_W:0]   addr_next;
    logic [ADDR_W:0]   remaining;
    logic [ADDR_W:0]   remaining_next;
    logic [TW-1:0]     tcnt;
    logic [TW-1:0]     tcnt_next;
    logic              mem_we_next;
    logic [ADDR_W-1:0] mem_addr_next;
    logic [31:0]       mem_wdata_next;

    logic              byte_ev;
    logic [31:0]       assembled;
    logic              timeout_hit;
    logic              hdr_too_big;

    // A byte arrives only on a rising edge of the receiver's ready level.
    assign byte_ev = rx_ready & ~rdy_q;

    // Status outputs decode directly from the state so that they follow the
    // asynchronous reset without any extra register.
    assign busy  = ((state == HDR) && (byte_idx != 2'd0)) || (state == DATA);
    assign done  = (state == DONE);
    assign error = (state == ERR);

    // The partially assembled word with the incoming byte dropped into the lane
    // selected by byte_idx; at byte_idx == 3 this is the complete word.
    always_comb begin
        assembled = word_q;
        case (byte_idx)
            2'd0:    assembled[7:0]   = rx_data;
            2'd1:    assembled[15:8]  = rx_data;
            2'd2:    assembled[23:16] = rx_data;
            default: assembled[31:24] = rx_data;
        endcase
    end

    assign hdr_too_big = {1'b0, assembled} > MAX_WORDS;

    // Fires in the idle cycle that takes the counter to TIMEOUT-1, so the
    // abort lands TIMEOUT cycles after the last byte event.
    assign timeout_hit = busy && !byte_ev && (tcnt == TO_HIT);

    // Next-state and datapath decode. Every byte in HDR/DATA advances byte_idx;
    // the fourth byte of a group either resolves the header or issues a write.
    always_comb begin
        state_next     = state;
        byte_idx_next  = byte_idx;
        word_next      = word_q;
        addr_next      = addr_cnt;
        remaining_next = remaining;
        tcnt_next      = tcnt;
        mem_we_next    = 1'b0;
        mem_addr_next  = mem_addr;
        mem_wdata_next = mem_wdata;

        if (byte_ev) begin
            tcnt_next = '0;
        end else if (busy) begin
            tcnt_next = tcnt + TW'(1);
        end

        case (state)
            HDR: begin
                if (byte_ev) begin
                    word_next     = assembled;
                    byte_idx_next = byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        if (assembled == 32'd0) begin
                            state_next = DONE;
                        end else if (hdr_too_big) begin
                            state_next = ERR;
                        end else begin
                            state_next     = DATA;
                            addr_next      = '0;
                            remaining_next = assembled[ADDR_W:0];
                        end
                    end
                end else if (timeout_hit) begin
                    state_next = ERR;
                end
            end

            DATA: begin
                if (byte_ev) begin
                    word_next     = assembled;
                    byte_idx_next = byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        mem_we_next    = 1'b1;
                        mem_addr_next  = addr_cnt[ADDR_W-1:0];
                        mem_wdata_next = assembled;
                        addr_next      = addr_cnt + 1'b1;
                        remaining_next = remaining - 1'b1;
                        // The final write and the DONE state become visible together.
                        if (remaining == {{ADDR_W{1'b0}}, 1'b1}) begin
                            state_next = DONE;
                        end
                    end
                end else if (timeout_hit) begin
                    state_next = ERR;
                end
            end

            // Terminal states: bytes are dropped, and restart wins over a
            // simultaneous byte event.
            default: begin
                if (restart) begin
                    state_next    = HDR;
                    byte_idx_next = 2'd0;
                    addr_next     = '0;
                    tcnt_next     = '0;
                end
            end
        endcase
    end

    // State and datapath registers. rdy_q resets high so that a receiver
    // already showing ready at reset release is not mistaken for a new byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HDR;
            rdy_q     <= 1'b1;
            byte_idx  <= 2'd0;
            word_q    <= '0;
            addr_cnt  <= '0;
            remaining <= '0;
            tcnt      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_next;
            rdy_q     <= rx_ready;
            byte_idx  <= byte_idx_next;
            word_q    <= word_next;
            addr_cnt  <= addr_next;
            remaining <= remaining_next;
            tcnt      <= tcnt_next;
            mem_we    <= mem_we_next;
            mem_addr  <= mem_addr_next;
            mem_wdata <= mem_wdata_next;
        end
    end

endmodule

// File: tb/tb_uart_word_loader.sv
// ============================================================================
// tb_uart_word_loader
//
// Self-checking bench for uart_word_loader. Bytes are sent as ready rising
// edges. A reference model derives the expected writes from the byte list:
// the header gives N, and word i is bytes 4+4i..7+4i at address i, written
// in the cycle after its last byte. A monitor records every mem_we pulse.
// ============================================================================
module tb_uart_word_loader;

    localparam int ADDR_W  = 12;
    localparam int TIMEOUT = 40;

    logic              clk;
    logic              rst_n;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              restart;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              error;

    uart_word_loader #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .restart   (restart),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    typedef struct {
        int                c;
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    int         compared;
    int         mismatched;
    int         cyc;
    int         long_pulses;
    logic       prev_we;
    wr_t        wr_q[$];
    wr_t        exp_q[$];
    logic [7:0] byte_q[$];
    int         ev_q[$];
    bit         exp_done;
    bit         exp_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Write monitor: logs each strobe with the cycle it was seen in.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_q.push_back('{cyc, mem_addr, mem_wdata});
            if (prev_we) long_pulses++;
        end
        prev_we = (mem_we === 1'b1);
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Reference model over the recorded byte list.
    task automatic build_expected();
        logic [31:0] n;
        exp_q.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (byte_q.size() < 4) return;
        n = {byte_q[3], byte_q[2], byte_q[1], byte_q[0]};
        if (n == 32'd0) begin
            exp_done = 1'b1;
            return;
        end
        if (n > (32'd1 << ADDR_W)) begin
            exp_err = 1'b1;
            return;
        end
        for (int i = 0; i < int'(n) && (4 * i + 7) < byte_q.size(); i++) begin
            exp_q.push_back('{ev_q[4*i+7], ADDR_W'(i),
                              {byte_q[4*i+7], byte_q[4*i+6], byte_q[4*i+5], byte_q[4*i+4]}});
        end
        exp_done = (exp_q.size() == int'(n));
    endtask

    task automatic clear_history();
        wr_q.delete();
        byte_q.delete();
        ev_q.delete();
        exp_q.delete();
    endtask

    // Called on a negedge; returns on the negedge right after the capturing edge.
    task automatic send_byte(input logic [7:0] b, input bit with_restart);
        rx_ready = 1'b0;
        @(negedge clk);
        rx_data  = b;
        rx_ready = 1'b1;
        restart  = with_restart;
        @(negedge clk);
        restart  = 1'b0;
        rx_data  = 8'($urandom);
        if (!with_restart) begin
            byte_q.push_back(b);
            ev_q.push_back(cyc);
        end
    endtask

    task automatic send_header(input logic [31:0] n);
        for (int k = 0; k < 4; k++) send_byte(n[8*k +: 8], 1'b0);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        rx_ready = 1'b1;
        rx_data  = 8'hA5;
        restart  = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if ({mem_we, mem_addr, mem_wdata, busy, done, error} !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: got we=%b addr=%0h data=%08h busy=%b done=%b err=%b required all 0",
                     mem_we, mem_addr, mem_wdata, busy, done, error);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        compared++;
        if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || wr_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL ready_high_release: got busy=%b done=%b err=%b writes=%0d required 0 0 0 0",
                     busy, done, error, wr_q.size());
        end
    endtask

    task automatic test_basic();
        logic [7:0] bytes [12] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22,
                                   8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        clear_history();
        send_byte(bytes[0], 1'b0);
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL busy_after_first_byte: got %b required 1", busy);
        end
        for (int k = 1; k < 12; k++) send_byte(bytes[k], 1'b0);
        compared++;
        if (done !== 1'b1 || mem_we !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL basic_done_with_last_write: got done=%b we=%b required 1 1", done, mem_we);
        end
        @(negedge clk);
        build_expected();
        compared++;
        if (wr_q.size() != 2 || exp_q.size() != 2) begin
            mismatched++;
            $display("[TB] FAIL basic_write_count: got %0d required 2", wr_q.size());
        end
        foreach (exp_q[i]) if (i < wr_q.size()) begin
            compared++;
            if (wr_q[i].a !== exp_q[i].a || wr_q[i].d !== exp_q[i].d || wr_q[i].c != exp_q[i].c) begin
                mismatched++;
                $display("[TB] FAIL basic_write[%0d]: got addr=%0h data=%08h cyc=%0d required addr=%0h data=%08h cyc=%0d",
                         i, wr_q[i].a, wr_q[i].d, wr_q[i].c, exp_q[i].a, exp_q[i].d, exp_q[i].c);
            end
        end
        pulse_restart();
    endtask

    task automatic test_zero_header();
        clear_history();
        send_header(32'd0);
        compared++;
        if (done !== 1'b1 || error !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL zero_header_done: got done=%b err=%b required 1 0", done, error);
        end
        @(negedge clk);
        compared++;
        if (wr_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL zero_header_writes: got %0d required 0", wr_q.size());
        end
        // Restart together with a byte: the byte must be dropped.
        send_byte(8'h5A, 1'b1);
        compared++;
        if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL restart_with_byte: got busy=%b done=%b err=%b required 0 0 0", busy, done, error);
        end
    endtask

    task automatic test_too_big();
        clear_history();
        send_header((32'd1 << ADDR_W) + 32'd1);
        build_expected();
        compared++;
        if (error !== exp_err || done !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL too_big_error: got err=%b done=%b required %b 0", error, done, exp_err);
        end
        @(negedge clk);
        compared++;
        if (wr_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL too_big_writes: got %0d required 0", wr_q.size());
        end
        pulse_restart();
    endtask

    task automatic test_timeout();
        int first_err;
        int last_ev;
        clear_history();
        send_header(32'd1);
        send_byte(8'($urandom), 1'b0);
        send_byte(8'($urandom), 1'b0);
        last_ev   = ev_q[ev_q.size()-1];
        first_err = -1;
        for (int k = 0; k < TIMEOUT + 10; k++) begin
            if (error === 1'b1) begin
                first_err = cyc;
                break;
            end
            @(negedge clk);
        end
        compared++;
        if (first_err != last_ev + TIMEOUT - 1) begin
            mismatched++;
            $display("[TB] FAIL timeout_cycle: got error at cyc %0d required %0d",
                     first_err, last_ev + TIMEOUT - 1);
        end
        compared++;
        if (wr_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL timeout_writes: got %0d required 0", wr_q.size());
        end
        pulse_restart();
    endtask

    task automatic test_random_loads();
        for (int ld = 0; ld < 4; ld++) begin
            int n;
            clear_history();
            n = $urandom_range(1, 5);
            send_header(32'(n));
            for (int k = 0; k < 4 * n; k++) begin
                repeat ($urandom_range(0, 6)) @(negedge clk);
                if (ld == 1 && k == 2) pulse_restart();
                send_byte(8'($urandom), 1'b0);
            end
            @(negedge clk);
            build_expected();
            compared++;
            if (done !== exp_done || error !== exp_err || wr_q.size() != exp_q.size()) begin
                mismatched++;
                $display("[TB] FAIL random_load%0d_status: got done=%b err=%b writes=%0d required %b %b %0d",
                         ld, done, error, wr_q.size(), exp_done, exp_err, exp_q.size());
            end
            foreach (exp_q[i]) if (i < wr_q.size()) begin
                compared++;
                if (wr_q[i].a !== exp_q[i].a || wr_q[i].d !== exp_q[i].d || wr_q[i].c != exp_q[i].c) begin
                    mismatched++;
                    $display("[TB] FAIL random_load%0d_write[%0d]: got addr=%0h data=%08h cyc=%0d required addr=%0h data=%08h cyc=%0d",
                             ld, i, wr_q[i].a, wr_q[i].d, wr_q[i].c, exp_q[i].a, exp_q[i].d, exp_q[i].c);
                end
            end
            pulse_restart();
        end
    endtask

    task automatic test_max_words();
        int n;
        clear_history();
        n = 1 << ADDR_W;
        send_header(32'(n));
        for (int k = 0; k < 4 * n; k++) send_byte(8'($urandom), 1'b0);
        @(negedge clk);
        build_expected();
        compared++;
        if (done !== 1'b1 || error !== 1'b0 || wr_q.size() != n || exp_q.size() != n) begin
            mismatched++;
            $display("[TB] FAIL max_words_status: got done=%b err=%b writes=%0d required 1 0 %0d",
                     done, error, wr_q.size(), n);
        end
        foreach (exp_q[i]) if (i < wr_q.size()) begin
            compared++;
            if (wr_q[i].a !== exp_q[i].a || wr_q[i].d !== exp_q[i].d || wr_q[i].c != exp_q[i].c) begin
                mismatched++;
                $display("[TB] FAIL max_words_write[%0d]: got addr=%0h data=%08h cyc=%0d required addr=%0h data=%08h cyc=%0d",
                         i, wr_q[i].a, wr_q[i].d, wr_q[i].c, exp_q[i].a, exp_q[i].d, exp_q[i].c);
            end
        end
        pulse_restart();
    endtask

    task automatic test_midload_reset();
        clear_history();
        send_header(32'd2);
        send_byte(8'hC3, 1'b0);
        send_byte(8'h3C, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        compared++;
        if ({mem_we, mem_addr, mem_wdata, busy, done, error} !== '0) begin
            mismatched++;
            $display("[TB] FAIL midload_reset_outputs: got we=%b addr=%0h data=%08h busy=%b done=%b err=%b required all 0",
                     mem_we, mem_addr, mem_wdata, busy, done, error);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        clear_history();
        send_header(32'd1);
        for (int k = 0; k < 4; k++) send_byte(8'($urandom), 1'b0);
        @(negedge clk);
        build_expected();
        compared++;
        if (done !== 1'b1 || wr_q.size() != 1 || exp_q.size() != 1) begin
            mismatched++;
            $display("[TB] FAIL post_reset_load_status: got done=%b writes=%0d required 1 1", done, wr_q.size());
        end
        foreach (exp_q[i]) if (i < wr_q.size()) begin
            compared++;
            if (wr_q[i].a !== exp_q[i].a || wr_q[i].d !== exp_q[i].d || wr_q[i].c != exp_q[i].c) begin
                mismatched++;
                $display("[TB] FAIL post_reset_write[%0d]: got addr=%0h data=%08h cyc=%0d required addr=%0h data=%08h cyc=%0d",
                         i, wr_q[i].a, wr_q[i].d, wr_q[i].c, exp_q[i].a, exp_q[i].d, exp_q[i].c);
            end
        end
    endtask

    initial begin
        compared    = 0;
        mismatched  = 0;
        cyc         = 0;
        long_pulses = 0;
        prev_we     = 1'b0;
        test_reset();
        test_basic();
        test_zero_header();
        test_too_big();
        test_timeout();
        test_random_loads();
        test_max_words();
        test_midload_reset();
        compared++;
        if (long_pulses != 0) begin
            mismatched++;
            $display("[TB] FAIL we_single_cycle: got %0d multi-cycle strobes required 0", long_pulses);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
